// File: rtl/e1_tx_buf_fetch.sv
// rtl/e1_tx_buf_fetch.sv - single-entry TX byte buffer fed from timeslot memory
//
// Holds one byte for the E1 TX core, tagged with its {multiframe, frame,
// timeslot} address. When the core presents an address the entry does not
// hold, one memory read is issued and the byte is latched on completion.
//
// Optional feature: define E1_TX_BUF_PREFETCH_EN to fetch the following
// address (timeslot, then frame, then multiframe order) as soon as the
// current byte is consumed. Without it every byte is fetched on demand.
//
// Ports:
//   clk        - single clock for all logic
//   rst_n      - asynchronous active-low reset
//   buf_ts     - timeslot requested by the TX core (5 bits)
//   buf_frame  - frame requested by the TX core (4 bits)
//   buf_mf     - multiframe requested by the TX core (MFW bits)
//   buf_re     - consume strobe from the TX core
//   buf_data   - byte held for the requested address
//   buf_rdy    - buf_data is valid for the presented address
//   mem_addr   - memory read address {mf, frame, ts}
//   mem_req    - memory read request, held until mem_ack
//   mem_ack    - read completion, mem_rdata valid in this cycle
//   mem_rdata  - memory read data
//   uflow      - sticky underflow: buf_re seen while buf_rdy low
//   uflow_clr  - clears uflow

module e1_tx_buf_fetch #(
    parameter int MFW = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [4:0]     buf_ts,
    input  logic [3:0]     buf_frame,
    input  logic [MFW-1:0] buf_mf,
    input  logic           buf_re,
    output logic [7:0]     buf_data,
    output logic           buf_rdy,
    output logic [MFW+8:0] mem_addr,
    output logic           mem_req,
    input  logic           mem_ack,
    input  logic [7:0]     mem_rdata,
    output logic           uflow,
    input  logic           uflow_clr
);

    localparam int AW = MFW + 9;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] tag;
    logic [7:0]    data_q;
    logic          valid;
    logic          uflow_q;

    logic [AW-1:0] req_addr;
    logic          hit;
    logic          consume;
    logic          underflow;

    assign req_addr  = {buf_mf, buf_frame, buf_ts};
    assign hit       = valid && (tag == req_addr);

    // Data is only offered while no fetch is in flight, so a byte landing
    // for a stale address never shows up as ready for the new one.
    assign buf_rdy   = (state == ST_IDLE) && hit;
    assign consume   = buf_re && buf_rdy;
    assign underflow = buf_re && !buf_rdy;

    assign buf_data  = data_q;
    assign mem_addr  = tag;
    assign mem_req   = (state == ST_FETCH);
    assign uflow     = uflow_q;

`ifdef E1_TX_BUF_PREFETCH_EN
    // Address that follows the current tag in transmit order:
    // timeslot first, carrying into frame, then into multiframe.
    logic [4:0]     tag_ts;
    logic [3:0]     tag_frame;
    logic [MFW-1:0] tag_mf;
    logic [AW-1:0]  tag_next;

    assign {tag_mf, tag_frame, tag_ts} = tag;

    always_comb begin
        tag_next = tag;
        if (tag_ts != 5'd31) begin
            tag_next = {tag_mf, tag_frame, tag_ts + 5'd1};
        end else if (tag_frame != 4'd15) begin
            tag_next = {tag_mf, tag_frame + 4'd1, 5'd0};
        end else begin
            tag_next = {tag_mf + MFW'(1), 4'd0, 5'd0};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            tag    <= '0;
            data_q <= '0;
            valid  <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (consume) begin
                valid <= 1'b0;
`ifdef E1_TX_BUF_PREFETCH_EN
                tag   <= tag_next;
                state <= ST_FETCH;
`endif
            end else if (!underflow && !hit) begin
                // A rejected consume leaves the entry untouched; only a
                // plain miss (or an empty entry) starts a new fetch.
                tag   <= req_addr;
                valid <= 1'b0;
                state <= ST_FETCH;
            end
        end else begin
            // The fetch always runs to completion, even if the core has
            // moved on; the new address is compared again back in idle.
            if (mem_ack) begin
                data_q <= mem_rdata;
                valid  <= 1'b1;
                state  <= ST_IDLE;
            end
        end
    end

    // Setting wins over clearing so an underflow in the clear cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uflow_q <= 1'b0;
        end else if (underflow) begin
            uflow_q <= 1'b1;
        end else if (uflow_clr) begin
            uflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_e1_tx_buf_fetch.sv
// tb/tb_e1_tx_buf_fetch.sv - self-checking bench for e1_tx_buf_fetch
module tb_e1_tx_buf_fetch;

    localparam int MFW   = 7;
    localparam int AW    = MFW + 9;
    localparam int AMASK = (1 << AW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4:0]     buf_ts;
    logic [3:0]     buf_frame;
    logic [MFW-1:0] buf_mf;
    logic           buf_re;
    logic [7:0]     buf_data;
    logic           buf_rdy;
    logic [AW-1:0]  mem_addr;
    logic           mem_req;
    logic           mem_ack;
    logic [7:0]     mem_rdata;
    logic           uflow;
    logic           uflow_clr;

    always #5 clk = ~clk;

    e1_tx_buf_fetch #(.MFW(MFW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buf_ts    (buf_ts),
        .buf_frame (buf_frame),
        .buf_mf    (buf_mf),
        .buf_re    (buf_re),
        .buf_data  (buf_data),
        .buf_rdy   (buf_rdy),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .uflow     (uflow),
        .uflow_clr (uflow_clr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cur_addr = 0;

    typedef struct {
        int         addr;
        bit         re;
        bit         ack;
        logic [7:0] rdata;
        bit         clr;
        bit         e_req;
        int         e_addr;
        bit         e_rdy;
        logic [7:0] e_data;
        bit         e_uflow;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_content(input int a);
        int t;
        t = (a * 13 + 7) ^ (a >> 5);
        return t[7:0];
    endfunction

    task automatic set_addr(input int a);
        logic [AW-1:0] v;
        v = a[AW-1:0];
        cur_addr = a & AMASK;
        {buf_mf, buf_frame, buf_ts} = v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int a, input bit re, input bit ack, input logic [7:0] rd,
                           input bit clr, input bit e_req, input int e_addr, input bit e_rdy,
                           input logic [7:0] e_data, input bit e_uflow);
        vec_t v;
        v.addr = a; v.re = re; v.ack = ack; v.rdata = rd; v.clr = clr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_rdy = e_rdy; v.e_data = e_data; v.e_uflow = e_uflow;
        vq.push_back(v);
    endtask

    // Starts from idle with address a missing; ends at the negedge of the hit cycle.
    task automatic fetch_and_hit(input int a, input logic [7:0] d);
        set_addr(a);
        buf_re = 1'b0; mem_ack = 1'b0; uflow_clr = 1'b0;
        @(negedge clk);
        chk("fh_miss_req", 32'(mem_req), 32'd0);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = d;
        @(negedge clk);
        chk("fh_req", 32'(mem_req), 32'd1);
        chk("fh_addr", 32'(mem_addr), 32'(a & AMASK));
        next_cycle();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        @(negedge clk);
        chk("fh_rdy", 32'(buf_rdy), 32'd1);
        chk("fh_data", 32'(buf_data), 32'(d));
    endtask

    // Demand-fetch counter: rising edges of mem_req while enabled.
    bit count_en = 1'b0;
    int n_fetch  = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (count_en && mem_req && !req_prev) n_fetch++;
        req_prev = mem_req;
    end

    // Reference model state.
    bit         m_busy, m_have, m_uflow;
    int         m_addr;
    logic [7:0] m_byte;

    initial begin
        rst_n = 1'b0; buf_re = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; uflow_clr = 1'b0;
        set_addr(0);

        // Directed table; row 0 is the first cycle after reset release.
        add_vec(0,    0, 0, 8'h00, 0,  0, 0,    0, 8'h00, 0);
        add_vec(0,    0, 1, 8'hA5, 0,  1, 0,    0, 8'h00, 0);
        add_vec(0,    0, 0, 8'h00, 0,  0, 0,    1, 8'hA5, 0);
        add_vec(5,    1, 0, 8'h00, 0,  0, 0,    0, 8'hA5, 0);
        add_vec(5,    0, 0, 8'h00, 1,  0, 0,    0, 8'hA5, 1);
        add_vec(5,    1, 0, 8'h00, 0,  1, 5,    0, 8'hA5, 0);
        add_vec(5,    1, 0, 8'h00, 1,  1, 5,    0, 8'hA5, 1);
        add_vec(5,    0, 1, 8'h3C, 0,  1, 5,    0, 8'hA5, 1);
        add_vec(5,    0, 0, 8'h00, 1,  0, 5,    1, 8'h3C, 1);
        add_vec(3,    0, 0, 8'h00, 0,  0, 5,    0, 8'h3C, 0);
        add_vec(9,    0, 0, 8'h00, 0,  1, 3,    0, 8'h3C, 0);
        add_vec(9,    0, 1, 8'h33, 0,  1, 3,    0, 8'h3C, 0);
        add_vec(9,    0, 0, 8'h00, 0,  0, 3,    0, 8'h33, 0);
        add_vec(9,    0, 1, 8'h99, 0,  1, 9,    0, 8'h33, 0);
        add_vec(9,    0, 0, 8'h00, 0,  0, 9,    1, 8'h99, 0);
        add_vec(1601, 0, 0, 8'h00, 0,  0, 9,    0, 8'h99, 0);
        add_vec(1601, 0, 1, 8'h5A, 0,  1, 1601, 0, 8'h99, 0);
        add_vec(1601, 0, 0, 8'h00, 0,  0, 1601, 1, 8'h5A, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdy", 32'(buf_rdy), 32'd0);
        chk("rst_data", 32'(buf_data), 32'd0);
        chk("rst_uflow", 32'(uflow), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        foreach (vq[i]) begin
            set_addr(vq[i].addr);
            buf_re = vq[i].re; mem_ack = vq[i].ack; mem_rdata = vq[i].rdata; uflow_clr = vq[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vq[i].e_req));
            chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vq[i].e_addr));
            chk($sformatf("vec%0d_rdy", i), 32'(buf_rdy), 32'(vq[i].e_rdy));
            chk($sformatf("vec%0d_data", i), 32'(buf_data), 32'(vq[i].e_data));
            chk($sformatf("vec%0d_uflow", i), 32'(uflow), 32'(vq[i].e_uflow));
            next_cycle();
        end
        buf_re = 1'b0; mem_ack = 1'b0; uflow_clr = 1'b0;

        // Reset in the middle of a fetch, then a stale ack after release.
        set_addr(0);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("midrst_req_before", 32'(mem_req), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_rdy", 32'(buf_rdy), 32'd0);
        chk("midrst_data", 32'(buf_data), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(negedge clk);
        chk("late_ack_rdy", 32'(buf_rdy), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rdy2", 32'(buf_rdy), 32'd0);
        chk("late_ack_req2", 32'(mem_req), 32'd1);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 32'(buf_rdy), 32'd1);
        chk("post_rst_data", 32'(buf_data), 32'hC3);
        next_cycle();

`ifdef E1_TX_BUF_PREFETCH_EN
        // Prefetch carries ts into frame, and full wrap to address 0.
        fetch_and_hit(31, 8'h11);
        buf_re = 1'b1;
        #1;
        chk("pf_consume_req", 32'(mem_req), 32'd0);
        next_cycle();
        buf_re = 1'b0;
        @(negedge clk);
        chk("pf_req", 32'(mem_req), 32'd1);
        chk("pf_addr_carry", 32'(mem_addr), 32'd32);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 8'h22;
        next_cycle();
        mem_ack = 1'b0;
        set_addr(32);
        @(negedge clk);
        chk("pf_hit_rdy", 32'(buf_rdy), 32'd1);
        chk("pf_hit_data", 32'(buf_data), 32'h22);
        next_cycle();
        fetch_and_hit(AMASK, 8'h44);
        buf_re = 1'b1;
        next_cycle();
        buf_re = 1'b0;
        @(negedge clk);
        chk("pf_wrap_req", 32'(mem_req), 32'd1);
        chk("pf_addr_wrap", 32'(mem_addr), 32'd0);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 8'h55;
        next_cycle();
        mem_ack = 1'b0;
`else
        // 32 on-demand fetches; never a request in a consume cycle.
        set_addr(0);
        buf_re = 1'b1;
        next_cycle();
        buf_re = 1'b0;
        count_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            fetch_and_hit(i, mem_content(i));
            buf_re = 1'b1;
            #1;
            chk($sformatf("demand%0d_consume_req", i), 32'(mem_req), 32'd0);
            next_cycle();
            buf_re = 1'b0;
        end
        @(negedge clk);
        count_en = 1'b0;
        chk("demand_fetch_count", 32'(n_fetch), 32'd32);
        next_cycle();
`endif

        // Randomized run against the reference model.
        rst_n = 1'b0; buf_re = 1'b0; mem_ack = 1'b0; uflow_clr = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        m_busy = 0; m_have = 0; m_uflow = 0; m_addr = 0; m_byte = 8'h00;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int  r;
            bit  p_rdy, under;
            r = $urandom_range(0, 9);
            if (r >= 8) set_addr($urandom_range(0, 3));
            else if (r >= 5) set_addr((cur_addr + 1) & AMASK);
            else if (r == 4 && $urandom_range(0, 3) == 0) set_addr($urandom_range(0, AMASK));
            buf_re    = ($urandom_range(0, 3) == 0);
            uflow_clr = ($urandom_range(0, 15) == 0);
            mem_ack   = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = mem_ack ? mem_content(int'(mem_addr)) : 8'($urandom_range(0, 255));

            p_rdy = !m_busy && m_have && (m_addr == cur_addr);
            @(negedge clk);
            chk("rnd_req", 32'(mem_req), 32'(m_busy));
            chk("rnd_addr", 32'(mem_addr), 32'(m_addr));
            chk("rnd_rdy", 32'(buf_rdy), 32'(p_rdy));
            chk("rnd_data", 32'(buf_data), 32'(m_byte));
            chk("rnd_uflow", 32'(uflow), 32'(m_uflow));

            under = buf_re && !p_rdy;
            if (under) m_uflow = 1;
            else if (uflow_clr) m_uflow = 0;
            if (m_busy) begin
                if (mem_ack) begin
                    m_byte = mem_content(m_addr);
                    m_have = 1;
                    m_busy = 0;
                end
            end else if (buf_re && p_rdy) begin
                m_have = 0;
`ifdef E1_TX_BUF_PREFETCH_EN
                m_addr = (m_addr + 1) & AMASK;
                m_busy = 1;
`endif
            end else if (!buf_re && !p_rdy) begin
                m_addr = cur_addr;
                m_have = 0;
                m_busy = 1;
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
